// File: rtl/ledpattern_gen.sv
// Switch-controlled LED pattern generator: prescaled or single-stepped advance
// through rotate-left/right, ping-pong and bar-fill patterns, with tick/wrap strobes.
module ledpattern_gen #(
  parameter int N_LEDS   = 4,
  parameter int NB_SEL   = 2,
  parameter int NB_COUNT = 32,
  parameter int BASE_EXP = 22
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NB_SEL-1:0] i_sel,
  input  logic [1:0]        i_mode,
  input  logic              i_step,
  input  logic              i_color,
  output logic [N_LEDS-1:0] o_led,
  output logic [N_LEDS-1:0] o_led_b,
  output logic [N_LEDS-1:0] o_led_g,
  output logic              o_tick,
  output logic              o_wrap
);

  localparam logic [N_LEDS-1:0] ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

  logic [NB_COUNT-1:0] counter;
  logic [N_LEDS-1:0]   pattern;
  logic                dir;
  logic [1:0]          mode_q;
  logic                step_q;

  logic [NB_COUNT-1:0] limit;
  logic                at_limit;
  logic                mode_same;
  logic                adv;
  logic [N_LEDS-1:0]   nxt;

  // Wraps to all-ones when BASE_EXP+sel equals NB_COUNT, which is the intended limit.
  function automatic logic [NB_COUNT-1:0] limit_of(input logic [NB_SEL-1:0] sel);
    logic [NB_COUNT-1:0] one;
    one = {{(NB_COUNT-1){1'b0}}, 1'b1};
    return (one << (BASE_EXP + int'(sel))) - one;
  endfunction

  function automatic logic [N_LEDS-1:0] next_pat(input logic [1:0] mode,
                                                 input logic [N_LEDS-1:0] p,
                                                 input logic d);
    case (mode)
      2'd0:    return {p[N_LEDS-2:0], p[N_LEDS-1]};
      2'd1:    return {p[0], p[N_LEDS-1:1]};
      2'd2:    return d ? (p >> 1) : (p << 1);
      default: return (&p) ? '0 : ((p << 1) | ONE);
    endcase
  endfunction

  assign limit     = limit_of(i_sel);
  assign at_limit  = (counter >= limit);
  assign mode_same = (i_mode == mode_q);
  assign adv       = mode_same & (i_enable ? at_limit : (i_step & ~step_q));
  assign nxt       = next_pat(mode_q, pattern, dir);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      counter <= '0;
      pattern <= ONE;
      dir     <= 1'b0;
      mode_q  <= i_mode;
      step_q  <= i_step;
      o_tick  <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      step_q <= i_step;
      if (!mode_same) begin
        mode_q  <= i_mode;
        pattern <= ONE;
        dir     <= 1'b0;
        counter <= '0;
        o_tick  <= 1'b0;
        o_wrap  <= 1'b0;
      end else begin
        if (i_enable)
          counter <= at_limit ? '0 : counter + 1'b1;
        if (adv) begin
          pattern <= nxt;
          // Ping-pong turns around in the same cycle the hot bit lands on an end.
          if (mode_q == 2'd2) begin
            if (nxt[N_LEDS-1])
              dir <= 1'b1;
            else if (nxt[0])
              dir <= 1'b0;
          end
        end
        o_tick <= adv;
        o_wrap <= adv && (nxt == ONE);
      end
    end
  end

  assign o_led   = pattern;
  assign o_led_b = i_color ? '0 : pattern;
  assign o_led_g = i_color ? pattern : '0;

endmodule

// File: tb/tb_ledpattern_gen.sv
// Bench for ledpattern_gen: phase-index reference model, directed scenarios and random run.
module tb_ledpattern_gen;
  localparam int N = 4, NB_SEL = 2, NB_COUNT = 8, BASE_EXP = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              i_reset, i_enable, i_step, i_color;
  logic [NB_SEL-1:0] i_sel;
  logic [1:0]        i_mode;
  logic [N-1:0]      o_led, o_led_b, o_led_g;
  logic              o_tick, o_wrap;

  int total = 0, bad = 0;

  // Model: counter as integer, pattern as a phase index into the mode's sequence.
  int       m_cnt, m_idx;
  logic [1:0] m_mode_q;
  logic     m_step_q, m_tick, m_wrap;

  ledpattern_gen #(.N_LEDS(N), .NB_SEL(NB_SEL), .NB_COUNT(NB_COUNT), .BASE_EXP(BASE_EXP)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sel(i_sel), .i_mode(i_mode),
    .i_step(i_step), .i_color(i_color), .o_led(o_led), .o_led_b(o_led_b), .o_led_g(o_led_g),
    .o_tick(o_tick), .o_wrap(o_wrap));

  function automatic int period_of(input logic [1:0] mode);
    case (mode)
      2'd0, 2'd1: return N;
      2'd2:       return 2 * N - 2;
      default:    return N + 1;
    endcase
  endfunction

  function automatic logic [N-1:0] pat_of(input logic [1:0] mode, input int idx);
    int v;
    case (mode)
      2'd0:    v = 1 << idx;
      2'd1:    v = 1 << ((N - idx) % N);
      2'd2:    v = 1 << ((idx < N) ? idx : (2 * N - 2 - idx));
      default: v = (idx < N) ? ((1 << (idx + 1)) - 1) : 0;
    endcase
    return v[N-1:0];
  endfunction

  function automatic logic [3*N+1:0] exp_vec();
    logic [N-1:0] p;
    p = pat_of(m_mode_q, m_idx);
    return {p, (i_color ? '0 : p), (i_color ? p : '0), m_tick, m_wrap};
  endfunction

  function automatic logic [3*N+1:0] dut_vec();
    return {o_led, o_led_b, o_led_g, o_tick, o_wrap};
  endfunction

  // Advances the model by one edge using the inputs now applied, then waits for that edge.
  task automatic cyc();
    int  lim;
    logic adv;
    if (i_reset) begin
      m_cnt = 0; m_idx = 0; m_mode_q = i_mode; m_tick = 0; m_wrap = 0;
    end else if (i_mode != m_mode_q) begin
      m_mode_q = i_mode; m_cnt = 0; m_idx = 0; m_tick = 0; m_wrap = 0;
    end else begin
      lim = (1 << (BASE_EXP + int'(i_sel))) - 1;
      adv = i_enable ? (m_cnt >= lim) : (i_step && !m_step_q);
      if (i_enable) m_cnt = (m_cnt >= lim) ? 0 : m_cnt + 1;
      if (adv) m_idx = (m_idx + 1) % period_of(m_mode_q);
      m_tick = adv;
      m_wrap = adv && (m_idx == 0);
    end
    m_step_q = i_step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1; i_enable = 0; i_sel = 0; i_mode = 0; i_step = 0; i_color = 0;
    cyc(); cyc();
    total++;
    if ({o_led, o_tick, o_wrap} !== {4'b0001, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_state got=%b want=%b", {o_led, o_tick, o_wrap}, 6'b000100);
    end
    i_reset = 0;
  endtask

  task automatic test_rotate();
    int ticks = 0;
    i_mode = 0; i_sel = 0; i_enable = 1;
    for (int c = 0; c < 24; c++) begin
      cyc();
      if (o_tick === 1'b1) ticks++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rotate c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
    total++;
    if (ticks != 6) begin
      bad++; $display("FAIL rotate_tick_count got=%0d want=6", ticks);
    end
  endtask

  task automatic test_pattern(input logic [1:0] mode, input logic [NB_SEL-1:0] sel, input int n);
    int wraps = 0;
    i_mode = mode; i_sel = sel; i_enable = 1;
    for (int c = 0; c < n; c++) begin
      i_color = 1'($urandom_range(0, 1));
      cyc();
      if (o_wrap === 1'b1) wraps++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL mode%0d c=%0d got=%b want=%b", mode, c, dut_vec(), exp_vec());
      end
    end
    total++;
    if (wraps < 1) begin
      bad++; $display("FAIL mode%0d_wrap_seen got=%0d want>=1", mode, wraps);
    end
  endtask

  task automatic test_sel_drop();
    int guard = 0;
    i_sel = 3;
    while (m_cnt != 20 && guard < 80) begin
      cyc(); guard++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL sel_run got=%b want=%b", dut_vec(), exp_vec());
      end
    end
    total++;
    if (m_cnt != 20) begin
      bad++; $display("FAIL sel_reach20 got=%0d want=20", m_cnt);
    end
    i_sel = 1;
    cyc();
    total++;
    if (o_tick !== 1'b1) begin
      bad++; $display("FAIL sel_drop_adv got=%b want=1", o_tick);
    end
    for (int c = 0; c < 20; c++) begin
      cyc();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL sel_after c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_step();
    int ticks = 0, mticks = 0;
    int lens[3] = '{1, 5, 1};
    i_enable = 0; i_step = 0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < lens[k] + 2; c++) begin
        i_step = (c < lens[k]);
        cyc();
        if (o_tick === 1'b1) ticks++;
        total++;
        if (dut_vec() !== exp_vec()) begin
          bad++; $display("FAIL step k=%0d c=%0d got=%b want=%b", k, c, dut_vec(), exp_vec());
        end
      end
    end
    total++;
    if (ticks != 3) begin
      bad++; $display("FAIL step_count got=%0d want=3", ticks);
    end
    i_enable = 1; i_step = 0;
    for (int c = 0; c < 20; c++) begin
      i_step = (c == 2);
      cyc();
      if (o_tick === 1'b1) ticks++;
      if (m_tick) mticks++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL step_enabled c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
    total++;
    if (ticks != 3 + mticks) begin
      bad++; $display("FAIL step_enabled_count got=%0d want=%0d", ticks, 3 + mticks);
    end
  endtask

  task automatic test_mode_change();
    int guard = 0;
    i_mode = 2; i_sel = 0; i_enable = 1;
    while (!(m_mode_q == 2 && m_idx == N) && guard < 80) begin
      cyc(); guard++;
    end
    i_mode = 0;
    cyc();
    total++;
    if ({o_led, o_tick, o_wrap} !== {4'b0001, 1'b0, 1'b0}) begin
      bad++; $display("FAIL mode_change got=%b want=%b", {o_led, o_tick, o_wrap}, 6'b000100);
    end
    for (int c = 0; c < 12; c++) begin
      cyc();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL mode_change_after c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
    i_reset = 1; i_mode = 1; i_step = 1;
    cyc();
    i_reset = 0;
    total++;
    if ({o_led, o_tick, o_wrap} !== {4'b0001, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midrun_reset got=%b want=%b", {o_led, o_tick, o_wrap}, 6'b000100);
    end
    for (int c = 0; c < 6; c++) cyc();
    for (int k = 0; k < 4; k++) begin
      i_color = k[0];
      #1;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL color k=%0d got=%b want=%b", k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      i_reset  = ($urandom_range(0, 99) < 2);
      i_enable = ($urandom_range(0, 9) >= 3);
      i_step   = 1'($urandom_range(0, 1));
      i_color  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 5) i_sel = NB_SEL'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) i_mode = 2'($urandom_range(0, 3));
      cyc();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random c=%0d got=%b want=%b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_pattern(2'd2, 2'd1, 60);
    test_pattern(2'd3, 2'd1, 50);
    test_pattern(2'd1, 2'd0, 20);
    test_sel_drop();
    test_step();
    test_mode_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ledpattern_gen.md
# ledpattern_gen

Parametrised LED pattern generator: next generation of the switch-controlled LED shift register. It is generalised in LED count, rate-selector width and counter width. It adds four pattern modes, a single-step input, and advance/wrap strobes. It sits between the board switches (or a VIO mux upstream) and the LED / RGB LED pins, and exposes `o_tick`/`o_wrap` as ILA trigger probes.

## Interface
- `N_LEDS`, 4: number of LEDs; must be ≥ 2.
- `NB_SEL`, 2: width of the rate selector; selects one of 2^NB_SEL limits.
- `NB_COUNT`, 32: prescaler counter width.
- `BASE_EXP`, 22: limit k = 2^(BASE_EXP+k) − 1 for k = 0 … 2^NB_SEL−1. Requires BASE_EXP + 2^NB_SEL − 1 ≤ NB_COUNT.

Ports:
- `clock`, in, 1: system clock. The block has one clock domain.
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_enable`, in, 1: run enable. When 0, the block holds its state.
- `i_sel`, in, NB_SEL: rate select k.
- `i_mode`, in, 2: pattern mode. 0 = rotate left, 1 = rotate right, 2 = ping-pong, 3 = bar fill.
- `i_step`, in, 1: single-step request. Acts on its rising edge, and only while `i_enable`=0.
- `i_color`, in, 1: RGB colour select. 0 = blue, 1 = green.
- `o_led`, out, N_LEDS: current pattern.
- `o_led_b`, out, N_LEDS: blue RGB LEDs.
- `o_led_g`, out, N_LEDS: green RGB LEDs.
- `o_tick`, out, 1: one-cycle pulse, high while a newly advanced pattern is first visible.
- `o_wrap`, out, 1: one-cycle pulse, high when the advance returned the pattern to the initial value 0…01.

## Operation
- State:
  - `counter` (NB_COUNT bits)
  - `pattern` (N_LEDS bits)
  - `dir`: 0 = moving left
  - `mode_q`: registered mode
  - `step_q`: previous `i_step`, for edge detection
- Reset: `counter`=0, `pattern`=0…01, `dir`=0, `mode_q`=`i_mode`, `step_q`=`i_step`, `o_tick`=0, `o_wrap`=0. Loading `mode_q` from `i_mode` means reset never causes a spurious mode re-initialisation.
- Limit: `limit` = 2^(BASE_EXP+`i_sel`) − 1. It is re-evaluated every cycle and may change at any time.
- Advance condition `adv` is true when either:
  - `i_enable`=1, `mode_q`=`i_mode` and `counter` ≥ `limit`; or
  - `i_enable`=0, `mode_q`=`i_mode`, `i_step`=1 and `step_q`=0.
- Counter:
  - `i_enable`=1: if `counter` ≥ `limit`, counter → 0; otherwise counter +1.
  - `i_enable`=0: counter holds.
  - Steps do not touch the counter.
- Mode change (`i_mode` ≠ `mode_q`), which has priority over everything except reset:
  - `mode_q` ← `i_mode`, `pattern` ← 0…01, `dir` ← 0, `counter` ← 0.
  - `o_tick` and `o_wrap` stay 0 in that cycle.
- Next pattern on `adv`:
  - Mode 0: rotate left, {p[N−2:0], p[N−1]}.
  - Mode 1: rotate right, {p[0], p[N−1:1]}.
  - Mode 2, ping-pong: a single hot bit moves left while `dir`=0 and right while `dir`=1.
    - On reaching bit N−1, `dir` ← 1 in the same cycle.
    - On reaching bit 0, `dir` ← 0 in the same cycle.
    - Sequence for N=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001 … (period 2N−2).
  - Mode 3, bar fill: if p = all ones, next is 0; otherwise next is (p<<1)|1. From 0 the next pattern is 0…01. Period N+1.
- `o_wrap`: registered as 1 on the edge where `adv` and the next pattern equals 0…01.
- `o_tick`: registered as `adv`.
- `o_led` = `pattern`.
- RGB outputs, combinational from `i_color`:
  - `o_led_b` = `i_color` ? 0 : `pattern`.
  - `o_led_g` = `i_color` ? `pattern` : 0.

## Timing
- Enabled, constant `i_sel`: the pattern advances every `limit`+1 cycles. After reset with `i_enable`=1, the first advance is visible `limit`+1 edges later.
- Lowering `i_sel` below the current `counter` value: advance on the next edge (≥ compare), then counter restarts at 0.
- Step: the new pattern and `o_tick` are visible one edge after `i_step` rises. Holding `i_step` high produces exactly one step. A rising edge while `i_enable`=1 is ignored, though `step_q` still tracks `i_step`.
- Mode change: the pattern is 0…01 one edge later. The next timed advance follows `limit`+1 cycles after that.
- Asserting `i_reset` mid-run overrides every other input on that edge.

## Test plan
Bench configuration: N_LEDS=4, NB_SEL=2, NB_COUNT=8, BASE_EXP=2, giving limits 3, 7, 15, 31.

1. Reset, then `i_mode`=0, `i_sel`=0, `i_enable`=1. Required: `o_led` goes 0001 → 0010 → 0100 → 1000 → 0001, one step every 4 cycles. `o_tick` pulses each advance; `o_wrap` pulses only on the return to 0001.
2. `i_mode`=2, `i_sel`=1. Required: sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, one step every 8 cycles. `o_wrap` pulses every 6 advances.
3. `i_mode`=3. Required: sequence 0001, 0011, 0111, 1111, 0000, 0001. `o_wrap` pulses on the 0000 → 0001 advance.
4. `i_sel`=3, run to `counter`=20, then set `i_sel`=1. Required: advance on the next edge, then every 8 cycles.
5. `i_enable`=0 with three `i_step` pulses, one of them held high for 5 cycles. Required: exactly three advances, counter frozen. A step issued while `i_enable`=1 causes no extra advance.
6. Change `i_mode` mid-run in ping-pong mode while `dir`=1. Required: `o_led`=0001 on the next edge with no tick, and rotation restarts leftward. `i_reset` pulsed mid-run returns the block to the reset state; toggling `i_color` moves `pattern` between `o_led_b` and `o_led_g` combinationally.
